// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, fence FSM encoding and scoreboard helper for the hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegDataW = 32;
  localparam int unsigned NumRegs  = 32;

  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [RegDataW-1:0] reg_data_t;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StAck   = 2'd2
  } fence_state_e;

  // True when a read source is waiting on an outstanding long-latency write.
  // x0 never has a pending writer.
  function automatic logic src_busy(input logic use_en, input reg_addr_t addr,
                                    input logic [NumRegs-1:0] busy);
    return use_en && (addr != '0) && busy[addr];
  endfunction

endpackage

// File: rtl/wb_arb.sv
// Register-file write-port arbiter: in-order pipeline writeback beats the long unit.
module wb_arb
  import hazard_ctrl_pkg::*;
(
  input  logic                pipe_wb_req_i,
  input  logic [RegAddrW-1:0] pipe_wb_addr_i,
  input  logic [RegDataW-1:0] pipe_wb_data_i,
  input  logic                lu_req_i,
  input  logic [RegAddrW-1:0] lu_addr_i,
  input  logic [RegDataW-1:0] lu_data_i,
  output logic                lu_ready_o,
  output logic                w_reg_req_o,
  output logic [RegAddrW-1:0] w_reg_addr_o,
  output logic [RegDataW-1:0] w_reg_data_o
);

  // Fixed-priority mux; an idle port drives zero address and data.
  always_comb begin
    lu_ready_o   = lu_req_i && !pipe_wb_req_i;
    w_reg_req_o  = 1'b0;
    w_reg_addr_o = '0;
    w_reg_data_o = '0;
    if (pipe_wb_req_i) begin
      w_reg_req_o  = 1'b1;
      w_reg_addr_o = pipe_wb_addr_i;
      w_reg_data_o = pipe_wb_data_i;
    end else if (lu_req_i) begin
      w_reg_req_o  = 1'b1;
      w_reg_addr_o = lu_addr_i;
      w_reg_data_o = lu_data_i;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue hazard control: long-latency scoreboard, outstanding counter, fence FSM.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid_i,
  input  logic                issue_long_i,
  input  logic [RegAddrW-1:0] issue_rd_addr_i,
  input  logic [RegAddrW-1:0] issue_rs1_addr_i,
  input  logic [RegAddrW-1:0] issue_rs2_addr_i,
  input  logic                issue_rs1_use_i,
  input  logic                issue_rs2_use_i,
  output logic                issue_ready_o,
  input  logic                flush_i,
  input  logic                pipe_wb_req_i,
  input  logic [RegAddrW-1:0] pipe_wb_addr_i,
  input  logic [RegDataW-1:0] pipe_wb_data_i,
  input  logic                lu_req_i,
  input  logic [RegAddrW-1:0] lu_addr_i,
  input  logic [RegDataW-1:0] lu_data_i,
  output logic                lu_ready_o,
  output logic                w_reg_req_o,
  output logic [RegAddrW-1:0] w_reg_addr_o,
  output logic [RegDataW-1:0] w_reg_data_o,
  input  logic                fence_req_i,
  output logic                fence_ack_o,
  output logic [NumRegs-1:0]  busy_o
);

  localparam int unsigned CntW = $clog2(LU_DEPTH + 1);

  logic [NumRegs-1:0] busy_q, busy_d;
  logic [CntW-1:0]    count_q, count_d;
  fence_state_e       state_q, state_d;

  logic rs1_stall, rs2_stall, waw_stall, full_stall, bubble_stall;
  logic fire, long_fire, grant, cnt_inc, cnt_dec;

  wb_arb u_wb_arb (
    .pipe_wb_req_i  (pipe_wb_req_i),
    .pipe_wb_addr_i (pipe_wb_addr_i),
    .pipe_wb_data_i (pipe_wb_data_i),
    .lu_req_i       (lu_req_i),
    .lu_addr_i      (lu_addr_i),
    .lu_data_i      (lu_data_i),
    .lu_ready_o     (lu_ready_o),
    .w_reg_req_o    (w_reg_req_o),
    .w_reg_addr_o   (w_reg_addr_o),
    .w_reg_data_o   (w_reg_data_o)
  );

  assign grant  = lu_ready_o;
  assign busy_o = busy_q;

  // Issue stall decision; a source hit on this cycle's grant is bypassed, not stalled.
  always_comb begin
    rs1_stall    = src_busy(issue_rs1_use_i, issue_rs1_addr_i, busy_q) &&
                   !(grant && (lu_addr_i == issue_rs1_addr_i));
    rs2_stall    = src_busy(issue_rs2_use_i, issue_rs2_addr_i, busy_q) &&
                   !(grant && (lu_addr_i == issue_rs2_addr_i));
    waw_stall    = issue_long_i && busy_q[issue_rd_addr_i];
    full_stall   = issue_long_i && (count_q == CntW'(LU_DEPTH));
    // Stall decode while the long unit is denied so the pipe leaves it a free slot.
    bubble_stall = lu_req_i && !grant;
    issue_ready_o = !(rs1_stall || rs2_stall || waw_stall || full_stall || bubble_stall ||
                      (state_q != StRun));
    fire      = issue_valid_i && issue_ready_o && !flush_i;
    long_fire = fire && issue_long_i && (issue_rd_addr_i != '0);
  end

  // Scoreboard next state: clear on grant, set on long issue, set wins on overlap.
  always_comb begin
    busy_d = busy_q;
    if (grant) begin
      busy_d[lu_addr_i] = 1'b0;
    end
    if (long_fire) begin
      busy_d[issue_rd_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Outstanding-op counter, saturating at zero on stray grants.
  always_comb begin
    cnt_inc = long_fire;
    cnt_dec = grant && (count_q != '0);
    count_d = count_q;
    if (cnt_inc && !cnt_dec) begin
      count_d = count_q + CntW'(1);
    end else if (!cnt_inc && cnt_dec) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Fence FSM next state; DRAIN looks at count_d so ACK lands the cycle after the last grant.
  always_comb begin
    state_d     = state_q;
    fence_ack_o = 1'b0;
    unique case (state_q)
      StRun: begin
        if (fence_req_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (count_d == '0) begin
          state_d = StAck;
        end
      end
      StAck: begin
        fence_ack_o = 1'b1;
        state_d     = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // State registers; reset abandons outstanding ops and any fence in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
      state_q <= StRun;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table plus fence and reset sequences.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid_i = 1'b0, issue_long_i = 1'b0;
  logic [4:0]  issue_rd_addr_i = '0, issue_rs1_addr_i = '0, issue_rs2_addr_i = '0;
  logic        issue_rs1_use_i = 1'b0, issue_rs2_use_i = 1'b0;
  logic        issue_ready_o;
  logic        flush_i = 1'b0;
  logic        pipe_wb_req_i = 1'b0;
  logic [4:0]  pipe_wb_addr_i = '0;
  logic [31:0] pipe_wb_data_i = '0;
  logic        lu_req_i = 1'b0;
  logic [4:0]  lu_addr_i = '0;
  logic [31:0] lu_data_i = '0;
  logic        lu_ready_o;
  logic        w_reg_req_o;
  logic [4:0]  w_reg_addr_o;
  logic [31:0] w_reg_data_o;
  logic        fence_req_i = 1'b0;
  logic        fence_ack_o;
  logic [31:0] busy_o;

  int n_pass = 0;
  int n_total = 0;

  hazard_ctrl #(.LU_DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid_i    (issue_valid_i),
    .issue_long_i     (issue_long_i),
    .issue_rd_addr_i  (issue_rd_addr_i),
    .issue_rs1_addr_i (issue_rs1_addr_i),
    .issue_rs2_addr_i (issue_rs2_addr_i),
    .issue_rs1_use_i  (issue_rs1_use_i),
    .issue_rs2_use_i  (issue_rs2_use_i),
    .issue_ready_o    (issue_ready_o),
    .flush_i          (flush_i),
    .pipe_wb_req_i    (pipe_wb_req_i),
    .pipe_wb_addr_i   (pipe_wb_addr_i),
    .pipe_wb_data_i   (pipe_wb_data_i),
    .lu_req_i         (lu_req_i),
    .lu_addr_i        (lu_addr_i),
    .lu_data_i        (lu_data_i),
    .lu_ready_o       (lu_ready_o),
    .w_reg_req_o      (w_reg_req_o),
    .w_reg_addr_o     (w_reg_addr_o),
    .w_reg_data_o     (w_reg_data_o),
    .fence_req_i      (fence_req_i),
    .fence_ack_o      (fence_ack_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, lng, flush;
    logic [4:0]  rd, rs1;
    logic        use1;
    logic [4:0]  rs2;
    logic        use2;
    logic        pipe_req;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        lu_req;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        e_ready, e_lu_ready, e_wreq;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic valid, lng, flush, input logic [4:0] rd, rs1, input logic use1,
    input logic [4:0] rs2, input logic use2,
    input logic pipe_req, input logic [4:0] pipe_addr, input logic [31:0] pipe_data,
    input logic lu_req, input logic [4:0] lu_addr, input logic [31:0] lu_data,
    input logic e_ready, e_lu_ready, e_wreq, input logic [4:0] e_waddr,
    input logic [31:0] e_wdata, input logic [31:0] e_busy);
    vec_t v;
    v.valid = valid; v.lng = lng; v.flush = flush; v.rd = rd; v.rs1 = rs1; v.use1 = use1;
    v.rs2 = rs2; v.use2 = use2; v.pipe_req = pipe_req; v.pipe_addr = pipe_addr;
    v.pipe_data = pipe_data; v.lu_req = lu_req; v.lu_addr = lu_addr; v.lu_data = lu_data;
    v.e_ready = e_ready; v.e_lu_ready = e_lu_ready; v.e_wreq = e_wreq;
    v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; issue_long_i = 1'b0; flush_i = 1'b0;
    issue_rd_addr_i = '0; issue_rs1_addr_i = '0; issue_rs2_addr_i = '0;
    issue_rs1_use_i = 1'b0; issue_rs2_use_i = 1'b0;
    pipe_wb_req_i = 1'b0; pipe_wb_addr_i = '0; pipe_wb_data_i = '0;
    lu_req_i = 1'b0; lu_addr_i = '0; lu_data_i = '0; fence_req_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic long_issue(input logic [4:0] rd);
    idle();
    issue_valid_i = 1'b1; issue_long_i = 1'b1; issue_rd_addr_i = rd;
  endtask

  task automatic lu_grant(input logic [4:0] a, input logic [31:0] d);
    idle();
    lu_req_i = 1'b1; lu_addr_i = a; lu_data_i = d;
  endtask

  initial begin
    // Reset state, held in reset
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_state", {issue_ready_o, lu_ready_o, w_reg_req_o, fence_ack_o, busy_o},
        {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    step();
    rst_n = 1'b1;

    // valid lng flush rd rs1 u1 rs2 u2 | pipe | lu | rdy lurdy wreq waddr wdata busy
    vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h0));
    vecs.push_back(mk(1,1,0, 5,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h0));
    vecs.push_back(mk(1,0,0, 0,5,1,0,0, 0,0,0,       0,0,0,          0,0,0,0,0,          32'h20));
    vecs.push_back(mk(1,0,0, 0,5,1,0,0, 0,0,0,       1,5,32'hAAAA,   1,1,1,5,32'hAAAA,   32'h20));
    vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h0));
    vecs.push_back(mk(0,0,0, 0,0,0,0,0, 1,3,32'h33,  1,7,32'h77,     0,0,1,3,32'h33,     32'h0));
    vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,       1,7,32'h77,     1,1,1,7,32'h77,     32'h0));
    vecs.push_back(mk(1,1,0, 0,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h0));
    vecs.push_back(mk(1,0,0, 0,0,1,0,1, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h0));
    vecs.push_back(mk(1,1,0, 1,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h0));
    vecs.push_back(mk(1,1,0, 2,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h2));
    vecs.push_back(mk(1,1,0, 3,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h6));
    vecs.push_back(mk(1,1,0, 4,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'hE));
    vecs.push_back(mk(1,1,0, 6,0,0,0,0, 0,0,0,       0,0,0,          0,0,0,0,0,          32'h1E));
    vecs.push_back(mk(1,0,0, 8,9,1,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h1E));
    vecs.push_back(mk(1,1,0, 6,0,0,0,0, 0,0,0,       1,1,32'h11,     0,1,1,1,32'h11,     32'h1E));
    vecs.push_back(mk(1,1,0, 6,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h1C));
    vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,       1,2,32'h22,     1,1,1,2,32'h22,     32'h5C));
    vecs.push_back(mk(1,1,1, 7,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h58));
    vecs.push_back(mk(1,0,0, 0,7,1,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h58));
    vecs.push_back(mk(1,1,0, 9,0,0,0,0, 0,0,0,       1,9,32'h99,     1,1,1,9,32'h99,     32'h58));
    vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h258));
    vecs.push_back(mk(1,1,0, 4,0,0,0,0, 0,0,0,       0,0,0,          0,0,0,0,0,          32'h258));
    vecs.push_back(mk(1,0,0, 0,0,0,6,1, 0,0,0,       0,0,0,          0,0,0,0,0,          32'h258));
    vecs.push_back(mk(1,0,0, 0,0,0,6,0, 0,0,0,       0,0,0,          1,0,0,0,0,          32'h258));

    foreach (vecs[i]) begin
      idle();
      issue_valid_i = vecs[i].valid; issue_long_i = vecs[i].lng; flush_i = vecs[i].flush;
      issue_rd_addr_i = vecs[i].rd; issue_rs1_addr_i = vecs[i].rs1;
      issue_rs1_use_i = vecs[i].use1; issue_rs2_addr_i = vecs[i].rs2;
      issue_rs2_use_i = vecs[i].use2;
      pipe_wb_req_i = vecs[i].pipe_req; pipe_wb_addr_i = vecs[i].pipe_addr;
      pipe_wb_data_i = vecs[i].pipe_data;
      lu_req_i = vecs[i].lu_req; lu_addr_i = vecs[i].lu_addr; lu_data_i = vecs[i].lu_data;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {issue_ready_o, lu_ready_o, w_reg_req_o, w_reg_addr_o, w_reg_data_o, fence_ack_o,
           busy_o},
          {vecs[i].e_ready, vecs[i].e_lu_ready, vecs[i].e_wreq, vecs[i].e_waddr,
           vecs[i].e_wdata, 1'b0, vecs[i].e_busy});
      step();
    end

    // Fence with two outstanding long ops
    do_reset();
    long_issue(5'd10);
    @(negedge clk); chk("fence_iss10", issue_ready_o, 1'b1); step();
    long_issue(5'd11);
    @(negedge clk); chk("fence_iss11", issue_ready_o, 1'b1); step();
    idle(); fence_req_i = 1'b1;
    @(negedge clk); chk("fence_req_run", {issue_ready_o, fence_ack_o}, 2'b10); step();
    idle(); issue_valid_i = 1'b1; issue_rs1_addr_i = 5'd20; issue_rs1_use_i = 1'b1;
    @(negedge clk); chk("fence_drain_stall", {issue_ready_o, fence_ack_o, busy_o},
                        {2'b00, 32'h0C00}); step();
    lu_grant(5'd10, 32'hA0);
    @(negedge clk); chk("fence_grant1", {issue_ready_o, lu_ready_o, fence_ack_o}, 3'b010); step();
    lu_grant(5'd11, 32'hB0);
    @(negedge clk); chk("fence_grant2", {issue_ready_o, lu_ready_o, fence_ack_o}, 3'b010); step();
    idle(); fence_req_i = 1'b1;  // must be ignored in ACK
    @(negedge clk); chk("fence_ack_pulse", {issue_ready_o, fence_ack_o, busy_o}, {2'b01, 32'h0});
    step();
    idle();
    @(negedge clk); chk("fence_back_run", {issue_ready_o, fence_ack_o}, 2'b10); step();

    // Fence with nothing outstanding still walks DRAIN then ACK
    idle(); fence_req_i = 1'b1;
    @(negedge clk); chk("fence0_req", {issue_ready_o, fence_ack_o}, 2'b10); step();
    idle();
    @(negedge clk); chk("fence0_drain", {issue_ready_o, fence_ack_o}, 2'b00); step();
    @(negedge clk); chk("fence0_ack", {issue_ready_o, fence_ack_o}, 2'b01); step();
    @(negedge clk); chk("fence0_run", {issue_ready_o, fence_ack_o}, 2'b10); step();

    // Reset in the middle of a drain with three outstanding
    long_issue(5'd1); step();
    long_issue(5'd2); step();
    long_issue(5'd3); step();
    idle(); fence_req_i = 1'b1; step();
    idle();
    @(negedge clk); chk("rst_pre_drain", {issue_ready_o, busy_o}, {1'b0, 32'hE});
    rst_n = 1'b0;
    #1;
    chk("rst_async", {fence_ack_o, busy_o}, {1'b0, 32'h0});
    step();
    rst_n = 1'b1;
    issue_valid_i = 1'b1; issue_rs1_addr_i = 5'd1; issue_rs1_use_i = 1'b1;
    #1;
    chk("rst_release", {issue_ready_o, fence_ack_o, busy_o}, {2'b10, 32'h0});
    step();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LU_DEPTH, default 4, maximum number of outstanding long-latency writebacks.
REQ-002 Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 clk  in  1  core clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 issue_valid_i  in  1  decode has an instruction to issue.
REQ-006 issue_long_i  in  1  instruction writes rd via long-latency unit (load/div).
REQ-007 issue_rd_addr_i, issue_rs1_addr_i, issue_rs2_addr_i  in  `reg_addr_bus  destination and source registers.
REQ-008 issue_rs1_use_i, issue_rs2_use_i  in  1  source operand actually read.
REQ-009 issue_ready_o  out  1  issue accepted this cycle; low = decode stall.
REQ-010 flush_i  in  1  cancel instruction in decode this cycle.
REQ-011 pipe_wb_req_i, pipe_wb_addr_i, pipe_wb_data_i  in  1/`reg_addr_bus/`reg_data_bus  in-order pipeline writeback.
REQ-012 lu_req_i, lu_addr_i, lu_data_i  in  1/`reg_addr_bus/`reg_data_bus  long-unit writeback request.
REQ-013 lu_ready_o  out  1  long-unit writeback granted this cycle.
REQ-014 w_reg_req_o, w_reg_addr_o, w_reg_data_o  out  1/`reg_addr_bus/`reg_data_bus  single regfile write port, also feeds the bypass unit.
REQ-015 fence_req_i  in  1  drain request; fence_ack_o  out  1  one-cycle drain-complete pulse.
REQ-016 busy_o  out  32  scoreboard bits, debug/observation.

Function
REQ-017 Fire = issue_valid_i && issue_ready_o && !flush_i; long fire = fire && issue_long_i && issue_rd_addr_i != 0.
REQ-018 issue_ready_o SHALL be low if any holds: rs1 used, nonzero, busy and not being granted by lu this cycle; same for rs2; long instruction with busy[rd] (WAW); long instruction with count == LU_DEPTH; lu_req_i && !lu_ready_o (bubble insertion); FSM not in RUN.
REQ-019 Source match against a same-cycle lu grant SHALL NOT stall, since that data is forwarded by the bypass unit.
REQ-020 busy[rd] SHALL set on long fire, visible next cycle; busy[lu_addr_i] SHALL clear on lu grant; a set and clear of the same bit in one cycle: set wins; busy[0] is always 0.
REQ-021 count SHALL increment on long fire and decrement on lu grant; both in the same cycle leaves it unchanged; a grant at count 0 leaves it at 0; the range is 0..LU_DEPTH.
REQ-022 Write port arbitration, combinational: pipe_wb_req_i has priority; lu_ready_o = lu_req_i && !pipe_wb_req_i; w_reg_* = pipe when pipe_wb_req_i, else lu when lu_req_i, else w_reg_req_o deasserted with address and data 0.
REQ-023 A denied lu request SHALL hold its address and data stable until granted; the stall rule of REQ-018 guarantees a grant once the pipeline writeback bubble arrives.
REQ-024 flush_i SHALL suppress the current issue only; it SHALL NOT clear busy or count.
REQ-025 FSM states RUN, DRAIN and ACK: RUN goes to DRAIN on fence_req_i; DRAIN goes to ACK when count == 0; ACK asserts fence_ack_o for one cycle, then returns to RUN; a request with count already 0 still takes RUN -> DRAIN -> ACK.
REQ-026 fence_req_i SHALL be ignored outside RUN.

Reset
REQ-027 On rst_n low, asynchronously: busy = 0, count = 0, FSM = RUN, fence_ack_o = 0.
REQ-028 Reset during DRAIN or with outstanding ops SHALL abandon them; the long unit is reset by the same rst_n.

Structure
REQ-029 `reg_addr_bus, `reg_data_bus, `write_reg_req_enable and the FSM state encodings SHALL live in define.v.
REQ-030 The write-port mux and priority logic SHALL be sub-module wb_arb; the scoreboard, counter and FSM stay in hazard_ctrl.

Verification
REQ-031 Long issue of rd=5, then the next cycle an issue reading rs1=5 -> issue_ready_o=0 until lu grant for addr 5; the grant cycle itself is not stalled.
REQ-032 pipe_wb_req_i and lu_req_i in the same cycle (addrs 3 and 7) -> w_reg_addr_o=3, lu_ready_o=0, issue_ready_o=0; next cycle with pipe idle -> addr 7 written, lu_ready_o=1.
REQ-033 Four long issues to rd 1..4 with LU_DEPTH=4 -> a fifth long issue stalls, a short issue with independent sources fires; one grant -> the fifth fires the next cycle.
REQ-034 Long issue to rd=0 -> busy_o stays 0 and count is unchanged; a later issue reading x0 never stalls.
REQ-035 fence_req_i with 2 outstanding -> issue_ready_o=0, fence_ack_o pulses exactly one cycle after the second grant, then the FSM is back in RUN.
REQ-036 rst_n asserted mid-DRAIN with count=3 -> busy_o=0, fence_ack_o=0 and issue_ready_o=1 immediately after release.
